// File: rtl/spi_cs_arbiter.sv
// rtl/spi_cs_arbiter.sv - round-robin SPI bus and chip-select arbiter with CS setup/hold/idle timing
// Optional bus reclaim from a requester that holds it too long: SPI_CS_ARB_TIMEOUT_EN
`timescale 1ns/1ps
module spi_cs_arbiter #(
    parameter int NumReq        = 3,
    parameter int CsSetupCycles = 2,
    parameter int CsHoldCycles  = 2,
    parameter int CsIdleCycles  = 1,
    parameter int TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    output logic [NumReq-1:0]         gnt_o,
    input  logic [NumReq-1:0]         req_sck_i,
    input  logic [NumReq-1:0]         req_copi_i,
    output logic [NumReq-1:0]         req_cipo_o,
    output logic                      sck_o,
    output logic                      copi_o,
    input  logic                      cipo_i,
    output logic [NumReq-1:0]         cs_no,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int OW    = $clog2(NumReq);
    localparam int MaxSh = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
    localparam int MaxPh = (MaxSh > CsIdleCycles) ? MaxSh : CsIdleCycles;
    localparam int PW    = $clog2(MaxPh + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_OWN   = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state, w_state_nxt;
    logic [OW-1:0]     r_owner, w_owner_nxt, r_rr_ptr, w_ptr_nxt;
    logic [OW-1:0]     w_winner, w_win_hi, w_win_lo;
    logic              w_found_hi, w_any, w_own_req, w_to_hit, w_cs_act;
    logic [PW-1:0]     r_phase;
    logic [NumReq-1:0] r_gnt, r_cs_n, w_elig, w_nxt_oh;

    assign w_any     = |w_elig;
    assign w_own_req = req_i[r_owner];

    // First eligible index at or above the pointer wins; otherwise the lowest one below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                if (k >= int'(r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = OW'(k);
                end else begin
                    w_win_lo = OW'(k);
                end
            end
        end
        w_winner  = w_found_hi ? w_win_hi : w_win_lo;
        w_ptr_nxt = (w_winner == OW'(NumReq - 1)) ? '0 : w_winner + OW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_SETUP;
                    w_owner_nxt = w_winner;
                end
            end
            S_SETUP: begin
                if (!w_own_req)                                w_state_nxt = S_HOLD;
                else if (r_phase == PW'(CsSetupCycles - 1))    w_state_nxt = S_OWN;
            end
            S_OWN: begin
                if (!w_own_req || w_to_hit)                    w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_phase == PW'(CsHoldCycles - 1))          w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_phase == PW'(CsIdleCycles - 1))          w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_nxt_oh = {{(NumReq-1){1'b0}}, 1'b1} << w_owner_nxt;
    assign w_cs_act = (w_state_nxt == S_SETUP) || (w_state_nxt == S_OWN) || (w_state_nxt == S_HOLD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_phase  <= '0;
            r_gnt    <= '0;
            r_cs_n   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (r_state == S_IDLE && w_any) r_rr_ptr <= w_ptr_nxt;
            if (w_state_nxt != r_state || w_state_nxt == S_IDLE || w_state_nxt == S_OWN)
                r_phase <= '0;
            else
                r_phase <= r_phase + PW'(1);
            r_gnt  <= (w_state_nxt == S_OWN) ? w_nxt_oh : '0;
            r_cs_n <= w_cs_act ? ~w_nxt_oh : '1;
        end
    end

`ifdef SPI_CS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0]     r_to_cnt;
    logic              r_timeout, w_to_fire;
    logic [NumReq-1:0] r_inelig, w_own_oh;

    assign w_own_oh  = {{(NumReq-1){1'b0}}, 1'b1} << r_owner;
    assign w_to_hit  = (r_to_cnt == TW'(TimeoutCycles - 1));
    assign w_to_fire = (r_state == S_OWN) && w_own_req && w_to_hit;
    assign w_elig    = req_i & ~r_inelig;

    // A reclaimed requester stays locked out until it is seen with its request low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_inelig  <= '0;
        end else begin
            r_to_cnt  <= (r_state == S_OWN && w_state_nxt == S_OWN) ? r_to_cnt + TW'(1) : '0;
            r_timeout <= w_to_fire;
            r_inelig  <= (r_inelig & req_i) | (w_to_fire ? w_own_oh : '0);
        end
    end
    assign timeout_o = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign w_elig    = req_i;
    assign timeout_o = 1'b0;
`endif

    assign gnt_o      = r_gnt;
    assign cs_no      = r_cs_n;
    assign owner_o    = r_owner;
    assign busy_o     = (r_state != S_IDLE);
    assign sck_o      = (r_state == S_OWN) & req_sck_i[r_owner];
    assign copi_o     = (r_state == S_OWN) & req_copi_i[r_owner];
    assign req_cipo_o = r_gnt & {NumReq{cipo_i}};
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// tb/tb_spi_cs_arbiter.sv - self-checking bench for spi_cs_arbiter with a timeline reference model
`timescale 1ns/1ps
module tb_spi_cs_arbiter;
    localparam int N = 3, SETUP = 2, HOLD = 2, IDLE = 1;
`ifdef SPI_CS_ARB_TIMEOUT_EN
    localparam int TO = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk, rst, sck, copi, cipo, busy, timeout;
    logic [N-1:0] req, gnt, req_sck, req_copi, req_cipo, cs_n;
    logic [1:0] owner;

    spi_cs_arbiter #(.NumReq(N), .CsSetupCycles(SETUP), .CsHoldCycles(HOLD),
                     .CsIdleCycles(IDLE), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .req_sck_i(req_sck),
        .req_copi_i(req_copi), .req_cipo_o(req_cipo), .sck_o(sck), .copi_o(copi),
        .cipo_i(cipo), .cs_no(cs_n), .owner_o(owner), .busy_o(busy), .timeout_o(timeout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a transaction is a timeline (start edge, grant edge, release edge) rather than states.
    int ec, m_grant_at, m_release, m_idle_at, m_owner, m_ptr;
    bit m_active;
    logic [N-1:0] m_inelig, exp_cs, exp_gnt;
    logic exp_busy, exp_to;
    logic [1:0] exp_owner;
    int n_cmp, n_fail, low_run, high_run, last_low, last_high;

    task automatic model_reset();
        ec = 0; m_active = 0; m_owner = 0; m_ptr = 0; m_inelig = '0;
        m_grant_at = 0; m_release = -1; m_idle_at = -1;
        low_run = 0; high_run = 0; last_low = 0; last_high = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        logic [N-1:0] elig;
        bit fire, found;
        int w;
        elig = r & ~m_inelig;
        fire = 0; found = 0; w = 0;
        if (m_active && m_release < 0) begin
            if (!r[m_owner]) m_release = ec;
            else if (TO_EN && ec == m_grant_at + TO) begin m_release = ec; fire = 1; end
            if (m_release >= 0) m_idle_at = m_release + HOLD + IDLE;
        end
        if (m_active && m_release >= 0 && ec >= m_release + HOLD) m_active = 0;
        m_inelig = m_inelig & r;
        if (fire) m_inelig[m_owner] = 1'b1;
        if (!m_active && ec > m_idle_at && elig != '0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!found && elig[k]) begin found = 1; w = k; end
            end
            m_active = 1; m_owner = w; m_ptr = (w + 1) % N;
            m_grant_at = ec + SETUP; m_release = -1;
        end
        exp_gnt   = (m_active && m_release < 0 && ec >= m_grant_at) ? (3'b001 << m_owner) : 3'b000;
        exp_cs    = m_active ? ~(3'b001 << m_owner) : 3'b111;
        exp_busy  = m_active || (ec < m_idle_at);
        exp_to    = fire;
        exp_owner = m_owner[1:0];
        ec++;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step(req);
        @(negedge clk);
        if (cs_n != 3'b111) begin
            if (high_run > 0) last_high = high_run;
            high_run = 0; low_run++;
        end else begin
            if (low_run > 0) last_low = low_run;
            low_run = 0; high_run++;
        end
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst = 1'b1; req = r; req_sck = '0; req_copi = '0; cipo = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            run_cycle();
            if (gnt != '0) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; req_sck = 3'b111; req_copi = 3'b111; cipo = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (cs_n !== 3'b111) begin n_fail++; $display("FAIL reset_cs got %b want 111", cs_n); end
        n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_cmp++; if (busy !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL reset_busy_owner got %b/%0d want 0/0", busy, owner); end
        n_cmp++; if ({sck, copi, timeout} !== 3'b000 || req_cipo !== 3'b000) begin n_fail++; $display("FAIL reset_bus got %b%b%b/%b want 000/000", sck, copi, timeout, req_cipo); end
        model_reset();
        rst = 1'b0;
        run_cycle();
        n_cmp++; if (cs_n !== 3'b110) begin n_fail++; $display("FAIL reset_first_cs got %b want 110", cs_n); end
        run_cycle();
        n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_early_gnt got %b want 000", gnt); end
        run_cycle();
        n_cmp++; if (gnt !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_gnt got %b/%b want 001/1", gnt, busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int own;
        logic [N-1:0] eg;
        do_reset(3'b111);
        for (int t = 0; t < 4; t++) begin
            wait_gnt(30, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_wait t=%0d got no grant want grant", t); end
            eg = 3'b001 << (t % 3);
            n_cmp++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_order t=%0d got %b want %b", t, gnt, eg); end
            if (t > 0) begin
                n_cmp++; if (last_low !== 9) begin n_fail++; $display("FAIL rr_cs_window t=%0d got %0d want 9", t, last_low); end
                n_cmp++; if (last_high !== 2) begin n_fail++; $display("FAIL rr_cs_gap t=%0d got %0d want 2", t, last_high); end
            end
            own = int'(owner);
            repeat (4) run_cycle();
            req[own] = 1'b0;
            run_cycle();
            req[own] = 1'b1;
            n_cmp++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rr_release t=%0d got %b want 000", t, gnt); end
        end
    endtask

    task automatic test_routing();
        bit ok;
        do_reset(3'b010);
        req_sck = 3'b001;
        run_cycle();
        req_sck = 3'b011; #1;
        n_cmp++; if (sck !== 1'b0 || cs_n !== 3'b101 || gnt !== 3'b000) begin n_fail++; $display("FAIL route_setup got sck=%b cs=%b gnt=%b want 0/101/000", sck, cs_n, gnt); end
        wait_gnt(5, ok);
        n_cmp++; if (!ok || gnt !== 3'b010) begin n_fail++; $display("FAIL route_gnt got %b want 010", gnt); end
        for (int i = 0; i < 6; i++) begin
            req_sck = {1'b0, i[0], 1'b1}; req_copi = 3'($urandom); cipo = 1'($urandom);
            #1;
            n_cmp++; if (sck !== i[0] || copi !== req_copi[1]) begin n_fail++; $display("FAIL route_own i=%0d got %b%b want %b%b", i, sck, copi, i[0], req_copi[1]); end
            n_cmp++; if (req_cipo !== {1'b0, cipo, 1'b0}) begin n_fail++; $display("FAIL route_cipo i=%0d got %b want 0%b0", i, req_cipo, cipo); end
            run_cycle();
        end
        req = 3'b000; req_sck = 3'b011; req_copi = 3'b111; cipo = 1'b1;
        run_cycle();
        n_cmp++; if (sck !== 1'b0 || copi !== 1'b0 || req_cipo !== 3'b000 || gnt !== 3'b000 || cs_n !== 3'b101) begin
            n_fail++; $display("FAIL route_hold got sck=%b copi=%b cipo=%b gnt=%b cs=%b want 0/0/000/000/101", sck, copi, req_cipo, gnt, cs_n);
        end
    endtask

    task automatic test_withdraw_setup();
        int lows;
        logic [N-1:0] gor;
        do_reset(3'b100);
        run_cycle();
        req = 3'b000;
        lows = (cs_n[2] == 1'b0) ? 1 : 0;
        gor = gnt;
        repeat (9) begin
            run_cycle();
            if (!cs_n[2]) lows++;
            gor = gor | gnt;
        end
        n_cmp++; if (lows !== 3) begin n_fail++; $display("FAIL withdraw_cs_len got %0d want 3", lows); end
        n_cmp++; if (gor !== 3'b000) begin n_fail++; $display("FAIL withdraw_gnt got %b want 000", gor); end
        n_cmp++; if (busy !== 1'b0 || cs_n !== 3'b111 || owner !== 2'd2) begin n_fail++; $display("FAIL withdraw_end got busy=%b cs=%b owner=%0d want 0/111/2", busy, cs_n, owner); end
    endtask

    task automatic test_reset_mid_own();
        bit ok;
        do_reset(3'b001);
        req_sck = 3'b001;
        wait_gnt(10, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_wait got no grant want grant"); end
        repeat (2) run_cycle();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (cs_n !== 3'b111 || gnt !== 3'b000) begin n_fail++; $display("FAIL midrst_release got cs=%b gnt=%b want 111/000", cs_n, gnt); end
        n_cmp++; if (busy !== 1'b0 || sck !== 1'b0) begin n_fail++; $display("FAIL midrst_bus got busy=%b sck=%b want 0/0", busy, sck); end
    endtask

    task automatic test_random();
        logic exp_sck, exp_copi;
        do_reset(3'b000);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(5) == 0) req[k] = ~req[k];
            req_sck = 3'($urandom); req_copi = 3'($urandom); cipo = 1'($urandom);
            run_cycle();
            exp_sck  = (exp_gnt != '0) ? req_sck[exp_owner] : 1'b0;
            exp_copi = (exp_gnt != '0) ? req_copi[exp_owner] : 1'b0;
            n_cmp++; if (cs_n !== exp_cs) begin n_fail++; $display("FAIL rand_cs c=%0d got %b want %b", c, cs_n, exp_cs); end
            n_cmp++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt c=%0d got %b want %b", c, gnt, exp_gnt); end
            n_cmp++; if (owner !== exp_owner) begin n_fail++; $display("FAIL rand_owner c=%0d got %0d want %0d", c, owner, exp_owner); end
            n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, exp_busy); end
            n_cmp++; if (timeout !== exp_to) begin n_fail++; $display("FAIL rand_timeout c=%0d got %b want %b", c, timeout, exp_to); end
            n_cmp++; if (sck !== exp_sck || copi !== exp_copi) begin n_fail++; $display("FAIL rand_bus c=%0d got %b%b want %b%b", c, sck, copi, exp_sck, exp_copi); end
            n_cmp++; if (req_cipo !== (exp_gnt & {N{cipo}})) begin n_fail++; $display("FAIL rand_cipo c=%0d got %b want %b", c, req_cipo, exp_gnt & {N{cipo}}); end
        end
    endtask

`ifdef SPI_CS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got1, served0;
        int cnt, pulses;
        do_reset(3'b011);
        wait_gnt(10, ok);
        n_cmp++; if (!ok || gnt !== 3'b001) begin n_fail++; $display("FAIL to_first_gnt got %b want 001", gnt); end
        cnt = 1; pulses = 0; got1 = 0;
        for (int i = 0; i < 60 && !got1; i++) begin
            run_cycle();
            if (gnt == 3'b001) cnt++;
            if (gnt == 3'b010) got1 = 1;
            if (timeout) begin
                pulses++;
                n_cmp++; if (gnt !== 3'b000 || cs_n !== 3'b110) begin n_fail++; $display("FAIL to_pulse_hold got gnt=%b cs=%b want 000/110", gnt, cs_n); end
            end
        end
        n_cmp++; if (cnt !== 16) begin n_fail++; $display("FAIL to_own_len got %0d want 16", cnt); end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL to_pulses got %0d want 1", pulses); end
        n_cmp++; if (!got1) begin n_fail++; $display("FAIL to_next_owner got %b want 010", gnt); end
        repeat (3) run_cycle();
        req = 3'b001;
        served0 = 0;
        repeat (40) begin
            run_cycle();
            if (gnt[0] || !cs_n[0]) served0 = 1;
        end
        n_cmp++; if (served0) begin n_fail++; $display("FAIL to_lockout got served=1 want 0"); end
        req = 3'b000;
        run_cycle();
        req = 3'b001;
        wait_gnt(15, ok);
        n_cmp++; if (!ok || gnt !== 3'b001) begin n_fail++; $display("FAIL to_regrant got %b want 001", gnt); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req = '0; req_sck = '0; req_copi = '0; cipo = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_routing();
        test_withdraw_setup();
        test_reset_mid_own();
        test_random();
`ifdef SPI_CS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_cs_arbiter.md
# spi_cs_arbiter

Shares one physical SPI bus (SCK, COPI, CIPO) among `NumReq` SPI host requesters, each with its own chip select. The arbiter grants the bus round-robin, drives the granted requester's chip select, and enforces chip-select setup, hold and inter-transaction idle times. It sits between the SPI host blocks inside `sonata_system` and the board pins, for example several hosts sharing the R-Pi SPI1 header with its CE0/CE1/CE2 lines. With `SPI_CS_ARB_TIMEOUT_EN` it also reclaims the bus from a requester that holds it too long.

## Interface
- `NumReq`, 3: number of requesters and chip selects (2..8).
- `CsSetupCycles`, 2: cycles CS is low before grant (>=1).
- `CsHoldCycles`, 2: cycles CS stays low after release (>=1).
- `CsIdleCycles`, 1: cycles all CS are high between transactions (>=1).
- `TimeoutCycles`, 1024: maximum OWN duration; used only with `SPI_CS_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in NumReq: bus request, level; held high for the whole transaction.
- `gnt_o` out NumReq: one-hot grant, registered.
- `req_sck_i` in NumReq: per-requester SCK.
- `req_copi_i` in NumReq: per-requester COPI.
- `req_cipo_o` out NumReq: per-requester CIPO.
- `sck_o` out 1: shared SCK pin.
- `copi_o` out 1: shared COPI pin.
- `cipo_i` in 1: shared CIPO pin.
- `cs_no` out NumReq: active-low chip selects, registered.
- `owner_o` out $clog2(NumReq): index of the current or last owner.
- `busy_o` out 1: high in any state other than IDLE.
- `timeout_o` out 1: one-cycle pulse on forced release; tied 0 when the macro is undefined.

## Operation
FSM states and transitions:
- IDLE -> SETUP when any eligible `req_i` is high. The winner is latched into `owner_o`.
- SETUP lasts `CsSetupCycles` cycles, then goes to OWN. If the owner drops `req_i` during SETUP, the FSM goes to HOLD and no grant is issued.
- OWN: `gnt_o[owner]`=1. The FSM stays in OWN while `req_i[owner]`=1. When `req_i[owner]` falls, it goes to HOLD.
- HOLD lasts `CsHoldCycles` cycles, then goes to GAP.
- GAP lasts `CsIdleCycles` cycles, then goes to IDLE.

Arbitration and pointer:
- The winner is the lowest index >= `rr_ptr` with an eligible request, wrapping around past NumReq-1.
- `rr_ptr` becomes (winner+1) mod NumReq on SETUP entry.
- `rr_ptr` resets to 0.

Chip select and bus routing:
- `cs_no[owner]`=0 in SETUP, OWN and HOLD. All CS are high in IDLE and GAP.
- Never more than one CS is low.
- `sck_o`/`copi_o` = `req_sck_i[owner]`/`req_copi_i[owner]` (combinational) in OWN only, otherwise 0.
- `req_cipo_o[k]` = `cipo_i` when `gnt_o[k]`, otherwise 0.
- Requests from non-owners are ignored until IDLE. Simultaneous requests are resolved by the pointer only.

Reset:
- `gnt_o`=0, `cs_no`=all ones, `sck_o`=0, `copi_o`=0, `owner_o`=0, `busy_o`=0, `timeout_o`=0, state=IDLE.
- Reset asserted mid-transaction releases CS immediately, without hold time.

Widths:
- Phase counter is $clog2(max(CsSetupCycles, CsHoldCycles, CsIdleCycles)+1) bits and is cleared on every state change.

## Timing
- Request-to-grant: `req_i` high at edge N in IDLE gives SETUP and CS low from N+1, and `gnt_o` high from N+1+CsSetupCycles.
- Release: `req_i` low sampled at edge M in OWN gives `gnt_o` low from M+1, CS high from M+1+CsHoldCycles, and the earliest next CS low at M+1+CsHoldCycles+CsIdleCycles+1.
- Back-to-back transactions by the same requester still pass through HOLD, GAP and IDLE.

## Configuration
`SPI_CS_ARB_TIMEOUT_EN`
- Defined:
  - A counter of $clog2(TimeoutCycles+1) bits runs in OWN.
  - When it reaches `TimeoutCycles`, the FSM goes to HOLD and `gnt_o` drops.
  - `timeout_o` pulses for one cycle, coincident with the first HOLD cycle.
  - The timed-out requester is ineligible until its `req_i` has been seen low for one cycle.
- Undefined: no counter is built, OWN is unbounded, and `timeout_o`=0.

## Test plan
- Reset with `req_i`=3'b111 held: `cs_no`=3'b111, `gnt_o`=0. After release with defaults, `cs_no`=3'b110 one cycle later and `gnt_o`=3'b001 three cycles later.
- Round-robin: `req_i`=3'b111 held, each owner drops `req_i` for one cycle after 5 OWN cycles -> grant order 0,1,2,0. Each CS low window = 2 + 5 + 2 cycles, with a 2-cycle all-high gap between windows.
- Routing: owner 1 toggles `req_sck_i[1]` while `req_sck_i[0]` is stuck at 1 -> `sck_o` follows requester 1 only in OWN. `req_cipo_o`=3'b010 pattern driven from `cipo_i`.
- Withdraw in SETUP: `req_i[2]` pulses for one cycle -> CS2 low for 1 + 2 cycles, no `gnt_o` ever, then IDLE.
- Reset mid-OWN: assert `rst_i` -> `cs_no`=all ones and `gnt_o`=0 asynchronously, with no hold time.
- With `SPI_CS_ARB_TIMEOUT_EN`, `TimeoutCycles`=16: owner 0 holds its request -> `gnt_o` drops after 16 OWN cycles and `timeout_o` pulses once. `req_i[1]` is served next. Requester 0 is not re-granted until it drops `req_i`.
